tpg_multimode: RTL and testbench
================================

Name: tpg_multimode

Overview:
- Parametrised LBIST test pattern generator; next generation of the single-mode LFSR TPG.
- Adds selectable pattern modes (LFSR, exhaustive counter, walking-one), a programmable pattern budget, and a start/valid/ready handshake toward the CUT/scan loader.
- Asserts END when the budget is exhausted.
- Sits between the BIST controller (start, mode) and the CUT input mux; the ORA counts accepted patterns via PATTERN_IDX.

Parameters:
- BITS, 4, pattern width (>=2)
- PATTERNS, 15, patterns issued per run (0 allowed)
- POLY, 4'b1100, LFSR tap mask; bit i set => pat[i] XORed into feedback
- SEED, 4'b0001, LFSR/walking-one start value; zero is replaced by 1
- CNT_W, $clog2(PATTERNS+1) (min 1), width of pattern index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin run (sampled in IDLE/DONE)
- mode  in  2  00 LFSR, 01 counter, 10 walking-one, 11 reserved (treated as LFSR)
- ready  in  1  consumer accepts TEST_PATTERN this cycle
- TEST_PATTERN  out  BITS  current pattern
- PATTERN_VALID  out  1  TEST_PATTERN is valid
- PATTERN_IDX  out  CNT_W  index of current pattern (0-based)
- BUSY  out  1  state == RUN
- END  out  1  run complete (sticky until next start or rst)

Behaviour:
- Clocking: all state changes on posedge clk. rst has priority over everything. On rst: state=IDLE; TEST_PATTERN=0; PATTERN_VALID=0; PATTERN_IDX=0; BUSY=0; END=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN (PATTERNS>0), or directly to DONE (PATTERNS==0).
  - RUN --last accept--> DONE.
  - DONE --start--> RUN (restart, END cleared the same edge).
- Start of run: mode is latched into an internal mode register; changes to mode during RUN are ignored. Cycle after start: TEST_PATTERN = initial value, PATTERN_VALID=1, PATTERN_IDX=0.
- Initial values by mode:
  - LFSR: SEED, or 1 if SEED==0.
  - Counter: 0.
  - Walking-one: SEED with all bits cleared except the lowest set bit (1 if SEED==0).
- Accept: PATTERN_VALID && ready. On accept, the next cycle presents the next pattern and PATTERN_IDX+1. Without accept, pattern and index hold; valid stays high (no drop while stalled).
- Next-pattern rules:
  - LFSR: Fibonacci shift-left, next = {pat[BITS-2:0], ^(pat & POLY)}.
  - Counter: pat+1 modulo 2^BITS (wraps).
  - Walking-one: rotate left by 1.
- Last pattern: on accept while PATTERN_IDX == PATTERNS-1:
  - Next cycle: state=DONE, PATTERN_VALID=0, END=1, BUSY=0.
  - TEST_PATTERN holds the last issued pattern; PATTERN_IDX holds PATTERNS-1.
- PATTERNS==0: start goes to DONE; END=1 the next cycle; no valid pattern is ever issued.
- start during RUN is ignored.
- Budget exceeding the period: if PATTERNS exceeds the sequence period (LFSR 2^BITS-1, counter 2^BITS, walking-one BITS), the sequence wraps and repeats. No error is flagged.
- rst mid-run: next cycle is the full reset state; any partially issued run is discarded.
- Latency: start to first valid = 1 cycle; accept to next pattern = 1 cycle; sustained throughput = 1 pattern/cycle with ready held high.

Optional Feature:
- Macro TPG_RESEED_EN.
- When defined, adds ports seed_in (in, BITS) and seed_load (in, 1), plus an internal seed register reset to SEED.
  - seed_load in IDLE/DONE writes the seed register. The new seed is used at the next start for LFSR and walking-one.
  - seed_load in RUN together with an accept replaces the next pattern with seed_in; zero is replaced by 1 in LFSR and walking-one modes. PATTERN_IDX still increments.
  - seed_load in RUN without an accept is ignored.
- When undefined: ports are absent; the seed is the constant SEED.

Test Plan:
- LFSR, BITS=4, POLY=1100, SEED=0001, PATTERNS=15, ready=1, pulse start:
  - Sequence 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000.
  - END=1 one cycle after the 15th accept; valid=0 at that point.
- Counter mode, PATTERNS=20, ready=1: sequence 0..15 then 0..3 (wrap); PATTERN_IDX reaches 19; END asserts.
- Walking-one, PATTERNS=6, ready toggling 1,0,0,1,...: each pattern holds while ready=0; sequence 0001,0010,0100,1000,0001,0010; valid never drops before END.
- rst asserted mid-run at PATTERN_IDX=7: next cycle all outputs are 0 and state IDLE. A following start restarts from SEED at index 0.
- PATTERNS=0: start produces END=1 next cycle with PATTERN_VALID never high. A second start in DONE clears END and again reaches DONE.
- (TPG_RESEED_EN) seed_load=1 with seed_in=1010 in IDLE, then start in LFSR mode: first pattern 1010, second 0101. seed_load with seed_in=0000 during an accept in RUN: next pattern 0001.

Source files
------------

// File: rtl/tpg_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tpg_multimode
// Brief    : Multi-mode LBIST test pattern generator (LFSR, counter,
//            walking-one) with a pattern budget and valid/ready handshake.
//            Optional macro TPG_RESEED_EN adds a run-time seed register
//            (ports seed_in / seed_load).
// Revision : 1.0 - initial release
// ============================================================================
module tpg_multimode #(
    parameter int              BITS     = 4,
    parameter int              PATTERNS = 15,
    parameter logic [BITS-1:0] POLY     = BITS'(4'b1100),
    parameter logic [BITS-1:0] SEED     = BITS'(4'b0001),
    parameter int              CNT_W    = (PATTERNS < 1) ? 1 : $clog2(PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             ready,
`ifdef TPG_RESEED_EN
    input  logic [BITS-1:0]  seed_in,
    input  logic             seed_load,
`endif
    output logic [BITS-1:0]  TEST_PATTERN,
    output logic             PATTERN_VALID,
    output logic [CNT_W-1:0] PATTERN_IDX,
    output logic             BUSY,
    output logic             END
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_mode_cnt  = 2'b01;
    localparam logic [1:0] c_mode_walk = 2'b10;

    localparam logic [BITS-1:0]  c_one      = BITS'(1);
    localparam logic [CNT_W-1:0] c_last_idx = (PATTERNS == 0) ? '0 : CNT_W'(PATTERNS - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [BITS-1:0]  r_pat;
    logic             r_valid;
    logic [CNT_W-1:0] r_idx;
    logic             r_end;

    logic [BITS-1:0]  w_seed;
    logic [BITS-1:0]  w_init;
    logic [BITS-1:0]  w_next;
    logic             w_accept;
    logic             w_last;

    // An all-zero value would lock up the LFSR / walking-one, so map it to 1.
    function automatic logic [BITS-1:0] f_nonzero(input logic [BITS-1:0] x);
        return (x == '0) ? c_one : x;
    endfunction

    // Isolate the lowest set bit (two's-complement trick).
    function automatic logic [BITS-1:0] f_low_bit(input logic [BITS-1:0] x);
        return x & (~x + c_one);
    endfunction

`ifdef TPG_RESEED_EN
    logic [BITS-1:0] r_seed;

    // Seed register is writable only between runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed <= SEED;
        end else if (seed_load && (r_state != c_st_run)) begin
            r_seed <= seed_in;
        end
    end

    assign w_seed = r_seed;
`else
    assign w_seed = SEED;
`endif

    assign w_accept = r_valid & ready;
    assign w_last   = (r_idx == c_last_idx);

    // First pattern of a run, chosen by the mode presented with start.
    always_comb begin
        w_init = f_nonzero(w_seed);
        case (mode)
            c_mode_cnt:  w_init = '0;
            c_mode_walk: w_init = f_low_bit(f_nonzero(w_seed));
            default:     w_init = f_nonzero(w_seed);
        endcase
    end

    // Successor of the current pattern under the latched mode.
    always_comb begin
        w_next = {r_pat[BITS-2:0], ^(r_pat & POLY)};
        case (r_mode)
            c_mode_cnt:  w_next = r_pat + c_one;
            c_mode_walk: w_next = {r_pat[BITS-2:0], r_pat[BITS-1]};
            default:     w_next = {r_pat[BITS-2:0], ^(r_pat & POLY)};
        endcase
`ifdef TPG_RESEED_EN
        if (seed_load) begin
            w_next = (r_mode == c_mode_cnt) ? seed_in : f_nonzero(seed_in);
        end
`endif
    end

    // Run control: IDLE/DONE wait for start, RUN issues one pattern per accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_mode  <= '0;
            r_pat   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_end   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_mode <= mode;
                        if (PATTERNS == 0) begin
                            // Zero budget: from IDLE finish at once; a restart
                            // from DONE drops END for one cycle, then re-asserts.
                            r_state <= c_st_done;
                            r_end   <= (r_state == c_st_idle);
                        end else begin
                            r_state <= c_st_run;
                            r_pat   <= w_init;
                            r_valid <= 1'b1;
                            r_idx   <= '0;
                            r_end   <= 1'b0;
                        end
                    end else if (r_state == c_st_done) begin
                        r_end <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= c_st_done;
                            r_valid <= 1'b0;
                            r_end   <= 1'b1;
                        end else begin
                            r_pat <= w_next;
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign TEST_PATTERN  = r_pat;
    assign PATTERN_VALID = r_valid;
    assign PATTERN_IDX   = r_idx;
    assign BUSY          = (r_state == c_st_run);
    assign END           = r_end;

endmodule
`default_nettype wire

// File: tb/tb_tpg_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpg_multimode
// Brief    : Scoreboard bench for tpg_multimode. Four instances with different
//            budgets (15, 20, 6, 0) share ready/mode/rst; each has its own start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpg_multimode;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_v;
    logic [1:0] mode;
    logic       ready;

    always #5 clk = ~clk;

    logic [3:0] p0, p1, p2, p3;
    logic       v0, v1, v2, v3;
    logic       b0, b1, b2, b3;
    logic       e0, e1, e2, e3;
    logic [3:0] i0;
    logic [4:0] i1;
    logic [2:0] i2;
    logic [0:0] i3;

    tpg_multimode #(.BITS(4), .PATTERNS(15), .POLY(4'b1100), .SEED(4'b0001)) u_dut_15 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .ready(ready),
        .TEST_PATTERN(p0), .PATTERN_VALID(v0), .PATTERN_IDX(i0), .BUSY(b0), .END(e0));

    tpg_multimode #(.BITS(4), .PATTERNS(20), .POLY(4'b1100), .SEED(4'b0001)) u_dut_20 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .ready(ready),
        .TEST_PATTERN(p1), .PATTERN_VALID(v1), .PATTERN_IDX(i1), .BUSY(b1), .END(e1));

    tpg_multimode #(.BITS(4), .PATTERNS(6), .POLY(4'b1100), .SEED(4'b0001)) u_dut_6 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .ready(ready),
        .TEST_PATTERN(p2), .PATTERN_VALID(v2), .PATTERN_IDX(i2), .BUSY(b2), .END(e2));

    tpg_multimode #(.BITS(4), .PATTERNS(0), .POLY(4'b1100), .SEED(4'b0001)) u_dut_0 (
        .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode), .ready(ready),
        .TEST_PATTERN(p3), .PATTERN_VALID(v3), .PATTERN_IDX(i3), .BUSY(b3), .END(e3));

    // Observation mux onto the instance under test.
    int         sel;
    logic [3:0] w_pat;
    logic       w_valid;
    logic [7:0] w_idx;
    logic       w_busy;
    logic       w_end;

    always_comb begin
        w_pat = p0; w_valid = v0; w_idx = 8'(i0); w_busy = b0; w_end = e0;
        case (sel)
            1: begin w_pat = p1; w_valid = v1; w_idx = 8'(i1); w_busy = b1; w_end = e1; end
            2: begin w_pat = p2; w_valid = v2; w_idx = 8'(i2); w_busy = b2; w_end = e2; end
            3: begin w_pat = p3; w_valid = v3; w_idx = 8'(i3); w_busy = b3; w_end = e3; end
            default: ;
        endcase
    end

    typedef struct {
        logic [3:0] pat;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference successor: POLY=1100 taps bits 3 and 2.
    function automatic logic [3:0] model_next(input logic [1:0] m, input logic [3:0] p);
        if (m == 2'b01)      return p + 4'd1;
        else if (m == 2'b10) return {p[2:0], p[3]};
        else                 return {p[2:0], p[3] ^ p[2]};
    endfunction

    task automatic push_seq(input logic [1:0] m, input int n);
        logic [3:0] p;
        p = (m == 2'b01) ? 4'b0000 : 4'b0001;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pat: p, idx: 8'(i)});
            p = model_next(m, p);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pat"},   w_pat,   0);
        chk({tag, "_valid"}, w_valid, 0);
        chk({tag, "_idx"},   w_idx,   0);
        chk({tag, "_busy"},  w_busy,  0);
        chk({tag, "_end"},   w_end,   0);
    endtask

    // One full run on instance s; stall gives ready = 1,0,0,1,0,0,...
    task automatic run(input int s, input logic [1:0] m, input int n, input bit stall);
        logic [3:0] last_pat;
        int         k;
        sel = s;
        sb.delete();
        push_seq(m, n);
        last_pat = (n > 0) ? sb[n-1].pat : 4'b0000;
        mode = m;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        mode = m ^ 2'b01;
        k = 0;
        while (sb.size() > 0 && k < 400) begin
            chk("valid_run", w_valid, 1);
            chk("busy_run", w_busy, 1);
            ready = stall ? (k % 3 == 0) : 1'b1;
            if (ready) begin
                chk("pattern", w_pat, sb[0].pat);
                chk("index", w_idx, sb[0].idx);
                void'(sb.pop_front());
            end else begin
                chk("hold_pattern", w_pat, sb[0].pat);
                chk("hold_index", w_idx, sb[0].idx);
            end
            k++;
            @(negedge clk);
        end
        ready = 1'b0;
        chk("timeout_remaining", sb.size(), 0);
        chk("end_set", w_end, 1);
        chk("valid_after_end", w_valid, 0);
        chk("busy_after_end", w_busy, 0);
        if (n > 0) begin
            chk("last_pattern_held", w_pat, last_pat);
            chk("last_index_held", w_idx, n - 1);
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; start_v = '0; mode = 2'b00; ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #0 check_all_zero("reset");
        end
        rst = 1'b0;
        @(negedge clk);

        run(0, 2'b00, 15, 1'b0);   // LFSR full period
        run(1, 2'b01, 20, 1'b0);   // counter wraps past 15
        run(2, 2'b10, 6,  1'b1);   // walking-one with stalls
        run(2, 2'b11, 6,  1'b0);   // reserved mode behaves as LFSR

        // Reset in the middle of a run at index 7.
        sel = 0; mode = 2'b00; start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0; ready = 1'b1; k = 0;
        while (w_idx != 8'd7 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx7", w_idx, 7);
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        @(negedge clk);
        run(0, 2'b00, 15, 1'b0);   // restart from SEED at index 0

        // Zero budget: first start, then a restart from DONE.
        run(3, 2'b00, 0, 1'b0);
        chk("zero_idx", w_idx, 0);
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v = '0;
        chk("zero_restart_end_clear", w_end, 0);
        chk("zero_restart_valid", w_valid, 0);
        @(negedge clk);
        chk("zero_restart_end_again", w_end, 1);
        chk("zero_restart_valid2", w_valid, 0);
        chk("zero_restart_busy", w_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
